// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature step scheduler: phase codes,
// joystick repeat states, saturation and Gray-code phase stepping.
package quad_pkg;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b10;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } joy_state_e;

  function automatic logic signed [31:0] sat_add(input logic signed [31:0] value,
                                                 input logic signed [31:0] limit);
    logic signed [31:0] res;
    if (value > limit) begin
      res = limit;
    end else if (value < -limit) begin
      res = -limit;
    end else begin
      res = value;
    end
    return res;
  endfunction

  // CW order is PH0->PH1->PH2->PH3; CCW walks it backwards
  function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic cw);
    logic [1:0] res;
    case (phase)
      PH0:     res = cw ? PH1 : PH3;
      PH1:     res = cw ? PH2 : PH0;
      PH2:     res = cw ? PH3 : PH1;
      PH3:     res = cw ? PH0 : PH2;
      default: res = PH0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/quad_phase_gen.sv
// Edge-rate tick generator plus Gray-code phase stepper; advances one edge
// per tick toward the sign of the pending count and reports the step taken.
module quad_phase_gen
  import quad_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic [DIV_W-1:0]  step_div,
  input  logic              pend_pos,
  input  logic              pend_neg,
  input  logic              hold,
  output logic              tick,
  output logic [1:0]        steer,
  output logic signed [1:0] emit
);

  logic [DIV_W-1:0] tick_cnt_r;
  logic [1:0]       steer_r;
  logic             tick_s;
  logic             step_s;

  assign tick_s = (tick_cnt_r == {DIV_W{1'b0}});
  assign step_s = tick_s && !hold && (pend_pos || pend_neg);
  assign tick   = tick_s;
  assign steer  = steer_r;

  // Down-counter; a new step_div is only picked up at reload
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_r <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= step_div;
    end else begin
      tick_cnt_r <= tick_cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Signed step reported back to the accumulator
  always_comb begin
    emit = 2'sd0;
    if (step_s && pend_pos) begin
      emit = 2'sd1;
    end else if (step_s) begin
      emit = -2'sd1;
    end else begin
      emit = 2'sd0;
    end
  end

  // Phase register, one edge per tick at most
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      steer_r <= PH0;
    end else if (step_s) begin
      steer_r <= next_phase(steer_r, pend_pos);
    end else begin
      steer_r <= steer_r;
    end
  end

endmodule

// File: rtl/quad_step_scheduler.sv
// Merges joystick auto-repeat steps and handshaked signed deltas into a
// saturating pending-step count that is drained as a quadrature stream.
module quad_step_scheduler
  import quad_pkg::*;
#(
  parameter int PEND_W      = 10,
  parameter int DIV_W       = 16,
  parameter int ACCEL_AFTER = 4
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic [DIV_W-1:0]         step_div,
  input  logic [7:0]               rep_slow,
  input  logic [7:0]               rep_fast,
  input  logic                     left,
  input  logic                     right,
  input  logic                     delta_valid,
  input  logic signed [7:0]        delta,
  output logic                     delta_ready,
  input  logic                     flush,
  output logic [1:0]               steer,
  output logic signed [PEND_W-1:0] pending,
  output logic                     busy
);

  localparam int SW = PEND_W + 2;
  localparam int PMAX = 2 ** (PEND_W - 1) - 1;
  // Headroom so that even a +127 delta cannot push past PMAX
  localparam logic [PEND_W-1:0] RDY_LIM = PEND_W'(PMAX - 128);
  localparam logic [7:0] ACCEL_N = 8'(ACCEL_AFTER);

  joy_state_e              state_r, state_n;
  logic [7:0]              rep_cnt_r, rep_cnt_n;
  logic [7:0]              nrep_r, nrep_n;
  logic signed [1:0]       held_dir_r, held_dir_n;
  logic signed [PEND_W-1:0] pending_r, pending_n;
  logic                    busy_r;

  logic signed [1:0]       dir_s, joy_step_s, emit_s;
  logic [7:0]              slow_eff_s, fast_eff_s;
  logic                    tick_s, pos_s, neg_s;
  logic [PEND_W-1:0]       abs_s;
  logic signed [SW-1:0]    delta_add_s, sum_s;

  assign slow_eff_s = (rep_slow == 8'd0) ? 8'd1 : rep_slow;
  assign fast_eff_s = (rep_fast == 8'd0) ? 8'd1 : rep_fast;
  assign pos_s      = !pending_r[PEND_W-1] && (pending_r != {PEND_W{1'b0}});
  assign neg_s      = pending_r[PEND_W-1];
  assign pending    = pending_r;
  assign busy       = busy_r;

  quad_phase_gen #(.DIV_W(DIV_W)) u_phase (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .step_div (step_div),
    .pend_pos (pos_s),
    .pend_neg (neg_s),
    .hold     (flush),
    .tick     (tick_s),
    .steer    (steer),
    .emit     (emit_s)
  );

  // Joystick direction; both pressed cancels out
  always_comb begin
    dir_s = 2'sd0;
    if (right && !left) begin
      dir_s = 2'sd1;
    end else if (left && !right) begin
      dir_s = -2'sd1;
    end else begin
      dir_s = 2'sd0;
    end
  end

  // Auto-repeat FSM: immediate step on press, slow repeats, then fast repeats
  always_comb begin
    state_n    = state_r;
    rep_cnt_n  = rep_cnt_r;
    nrep_n     = nrep_r;
    held_dir_n = held_dir_r;
    joy_step_s = 2'sd0;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (dir_s != 2'sd0) begin
            joy_step_s = dir_s;
            rep_cnt_n  = slow_eff_s;
            nrep_n     = 8'd0;
            held_dir_n = dir_s;
            state_n    = SLOW;
          end else begin
            state_n = IDLE;
          end
        end
        SLOW: begin
          if (dir_s != held_dir_r) begin
            state_n = IDLE;
          end else if (tick_s && rep_cnt_r <= 8'd1) begin
            joy_step_s = dir_s;
            nrep_n     = nrep_r + 8'd1;
            if (nrep_n == ACCEL_N) begin
              rep_cnt_n = fast_eff_s;
              state_n   = FAST;
            end else begin
              rep_cnt_n = slow_eff_s;
            end
          end else if (tick_s) begin
            rep_cnt_n = rep_cnt_r - 8'd1;
          end else begin
            state_n = SLOW;
          end
        end
        FAST: begin
          if (dir_s != held_dir_r) begin
            state_n = IDLE;
          end else if (tick_s && rep_cnt_r <= 8'd1) begin
            joy_step_s = dir_s;
            rep_cnt_n  = fast_eff_s;
          end else if (tick_s) begin
            rep_cnt_n = rep_cnt_r - 8'd1;
          end else begin
            state_n = FAST;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Delta acceptance is gated on magnitude, so only the joystick can saturate
  always_comb begin
    abs_s       = pending_r;
    delta_ready = 1'b0;
    if (pending_r[PEND_W-1]) begin
      abs_s = ~pending_r + {{(PEND_W-1){1'b0}}, 1'b1};
    end else begin
      abs_s = pending_r;
    end
    if (reset_n && !flush && (abs_s <= RDY_LIM)) begin
      delta_ready = 1'b1;
    end else begin
      delta_ready = 1'b0;
    end
  end

  // Accumulator next value: all contributions summed wide, then clamped
  always_comb begin
    delta_add_s = {SW{1'b0}};
    if (delta_valid && delta_ready) begin
      delta_add_s = SW'(delta);
    end else begin
      delta_add_s = {SW{1'b0}};
    end
    sum_s     = SW'(pending_r) - SW'(emit_s) + SW'(joy_step_s) + delta_add_s;
    pending_n = PEND_W'(sat_add(32'(sum_s), PMAX));
    if (flush) begin
      pending_n = {PEND_W{1'b0}};
    end else begin
      pending_n = pending_n;
    end
  end

  // State and accumulator registers
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      rep_cnt_r  <= 8'd0;
      nrep_r     <= 8'd0;
      held_dir_r <= 2'sd0;
      pending_r  <= {PEND_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      rep_cnt_r  <= rep_cnt_n;
      nrep_r     <= nrep_n;
      held_dir_r <= held_dir_n;
      pending_r  <= pending_n;
      busy_r     <= (pending_n != {PEND_W{1'b0}});
    end
  end

endmodule

// File: tb/tb_quad_step_scheduler.sv
// Scoreboard bench: a cycle-level behavioural model predicts pending/steer/busy
// for each clock; a negedge monitor pops and compares the predictions.
module tb_quad_step_scheduler;

  localparam int ACCEL = 4;
  localparam int PMAX  = 511;

  logic              CLK = 1'b0;
  logic              reset_n = 1'b0;
  logic [15:0]       step_div = 16'd0;
  logic [7:0]        rep_slow = 8'd1, rep_fast = 8'd1, delta = 8'd0;
  logic              left = 1'b0, right = 1'b0, delta_valid = 1'b0, flush = 1'b0;
  logic              delta_ready, busy;
  logic [1:0]        steer;
  logic signed [9:0] pending;

  quad_step_scheduler dut (
    .CLK(CLK), .reset_n(reset_n), .step_div(step_div), .rep_slow(rep_slow),
    .rep_fast(rep_fast), .left(left), .right(right), .delta_valid(delta_valid),
    .delta(delta), .delta_ready(delta_ready), .flush(flush), .steer(steer),
    .pending(pending), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct { int pend; int st; int bsy; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int passed = 0;

  // Model state: pending count, phase index into the CW sequence, cycles to next tick,
  // held joystick direction, ticks since last repeat, repeats issued
  int m_pend, m_ph, m_tcnt, m_held, m_since, m_reps;
  logic [1:0] cw_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int interval();
    if (m_reps < ACCEL) return (rep_slow == 8'd0) ? 1 : int'(rep_slow);
    return (rep_fast == 8'd0) ? 1 : int'(rep_fast);
  endfunction

  always @(negedge CLK) begin
    if (reset_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pending", int'(pending), e.pend);
      chk("steer", int'(steer), e.st);
      chk("busy", int'(busy), e.bsy);
    end
  end

  task automatic do_reset(input logic [15:0] sd, input logic [7:0] rs, input logic [7:0] rf);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    left = 1'b0; right = 1'b0; delta_valid = 1'b0; delta = 8'd0; flush = 1'b0;
    step_div = sd; rep_slow = rs; rep_fast = rf;
    #1;
    chk("rst_pending", int'(pending), 0);
    chk("rst_steer", int'(steer), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(delta_ready), 0);
    m_pend = 0; m_ph = 0; m_tcnt = 0; m_held = 0; m_since = 0; m_reps = 0;
    @(posedge CLK);
    #2 reset_n = 1'b1;
  endtask

  task automatic cyc(input bit l, input bit r, input bit dv, input logic [7:0] d, input bit f);
    bit tick, rdy;
    int dir, emit, joy, sum, mag;
    exp_t e;
    @(negedge CLK);
    left = l; right = r; delta_valid = dv; delta = d; flush = f;
    #1;
    tick = (m_tcnt == 0);
    mag  = (m_pend < 0) ? -m_pend : m_pend;
    rdy  = (mag <= PMAX - 128) && !f;
    chk("delta_ready", int'(delta_ready), int'(rdy));
    emit = 0;
    if (tick && !f && m_pend != 0) begin
      emit = (m_pend > 0) ? 1 : -1;
      m_ph = (m_ph + emit + 4) % 4;
    end
    dir = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
    joy = 0;
    if (f) m_held = 0;
    else if (m_held == 0) begin
      if (dir != 0) begin joy = dir; m_held = dir; m_since = 0; m_reps = 0; end
    end else if (dir != m_held) m_held = 0;
    else if (tick) begin
      m_since++;
      if (m_since >= interval()) begin joy = dir; m_reps++; m_since = 0; end
    end
    sum = m_pend - emit + joy + ((dv && rdy) ? int'($signed(d)) : 0);
    if (sum > PMAX) sum = PMAX;
    if (sum < -PMAX) sum = -PMAX;
    m_pend = f ? 0 : sum;
    m_tcnt = tick ? int'(step_div) : m_tcnt - 1;
    e.pend = m_pend; e.st = int'(cw_seq[m_ph]); e.bsy = (m_pend != 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  initial begin
    bit l, r;
    // delta +3 drained CW at one edge per 4 clocks
    do_reset(16'd3, 8'd2, 8'd1);
    cyc(0, 0, 1, 8'd3, 0);
    repeat (14) cyc(0, 0, 0, 8'd0, 0);

    // right held: press step, four slow repeats, then fast
    do_reset(16'd0, 8'd2, 8'd1);
    repeat (20) cyc(0, 1, 0, 8'd0, 0);
    repeat (3) cyc(0, 0, 0, 8'd0, 0);

    // both pressed then right released -> single CCW step
    do_reset(16'd5, 8'd50, 8'd50);
    repeat (4) cyc(1, 1, 0, 8'd0, 0);
    cyc(1, 0, 0, 8'd0, 0);
    repeat (10) cyc(0, 0, 0, 8'd0, 0);

    // delta_ready threshold, then joystick saturation at PMAX
    do_reset(16'd7, 8'd50, 8'd50);
    repeat (3) cyc(0, 0, 1, 8'd127, 0);
    cyc(0, 0, 1, 8'd3, 0);
    repeat (12) cyc(0, 0, 1, 8'd127, 0);
    repeat (4) begin cyc(0, 1, 0, 8'd0, 0); cyc(0, 0, 0, 8'd0, 0); end
    cyc(0, 0, 1, 8'h81, 0);

    // flush together with an offered delta
    do_reset(16'd200, 8'd2, 8'd1);
    cyc(0, 0, 1, 8'd5, 0);
    cyc(0, 0, 0, 8'd0, 0);
    cyc(0, 0, 1, 8'd10, 1);
    repeat (3) cyc(0, 0, 0, 8'd0, 0);

    // async reset in the middle of draining
    do_reset(16'd1, 8'd2, 8'd1);
    cyc(0, 0, 1, 8'd9, 0);
    repeat (4) cyc(0, 0, 0, 8'd0, 0);
    do_reset(16'd1, 8'd2, 8'd1);

    // randomized traffic
    for (int k = 0; k < 4; k++) begin
      do_reset(16'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 2)));
      l = 1'b0; r = 1'b0;
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 9) == 0) l = ~l;
        if ($urandom_range(0, 9) == 0) r = ~r;
        cyc(l, r, ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 24) == 0));
      end
    end

    cyc(0, 0, 0, 8'd0, 0);
    repeat (2) @(negedge CLK);
    #2;
    chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/quad_step_scheduler.md
Name: quad_step_scheduler

Overview:
- Schedules quadrature steps for the paddle/spinner input path.
- Merges two step sources into one signed pending-step accumulator:
  - a digital joystick, with hold-time auto-repeat and acceleration;
  - a signed delta port with a valid/ready handshake (mouse/analog spinner).
- Drains the accumulator as a 2-bit Gray-code quadrature stream at a programmable edge rate.
- Sits between the input-mapping logic and the game core's steering input.

Parameters:
- PEND_W, 10: width of the signed pending accumulator; saturation limit PMAX = 2^(PEND_W-1)-1.
- DIV_W, 16: width of step_div.
- ACCEL_AFTER, 4: number of slow auto-repeats before switching to the fast repeat interval.

Ports:
- CLK  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- step_div  in  DIV_W  clocks per quadrature edge minus 1.
- rep_slow  in  8  joystick repeat interval in ticks, initial phase; 0 is treated as 1.
- rep_fast  in  8  joystick repeat interval in ticks, accelerated phase; 0 is treated as 1.
- left  in  1  joystick left; synchronous to CLK.
- right  in  1  joystick right; synchronous to CLK.
- delta_valid  in  1  delta offer.
- delta  in  8  signed step count; positive = CW.
- delta_ready  out  1  delta accepted when valid && ready.
- flush  in  1  synchronous clear of pending steps.
- steer  out  2  quadrature phase output.
- pending  out  PEND_W  signed current accumulator value.
- busy  out  1  pending != 0.

Behaviour:
- Reset values (async, reset_n=0):
  - steer=00, pending=0, busy=0, delta_ready=0.
  - Tick counter=0; joystick FSM=IDLE; repeat counter=0; nrep=0.
- Tick generator:
  - Down-counter. tick=1 when the counter is 0, and the counter then reloads step_div.
  - step_div=0 gives a tick every clock. A new step_div takes effect at the next reload.
  - The first tick after reset release occurs on the first clock.
- Phase stepper, on tick only:
  - pending>0: advance CW (00→10→11→01→00) and decrement pending by 1.
  - pending<0: advance CCW (00→01→11→10→00) and increment pending by 1.
  - pending=0: steer holds.
  - At most one edge per tick; steer is registered.
- Joystick direction:
  - dir=+1 when right&&!left.
  - dir=-1 when left&&!right.
  - Otherwise dir=0; both pressed means no motion.
- Joystick FSM states IDLE, SLOW, FAST:
  - IDLE: if dir!=0, issue joy_step=dir this cycle, load rep_cnt=max(rep_slow,1), set nrep=0, go to SLOW.
  - SLOW: on tick, decrement rep_cnt. When rep_cnt reaches 0, issue joy_step=dir and increment nrep.
    - If nrep reaches ACCEL_AFTER, load rep_fast and go to FAST.
    - Otherwise reload rep_slow.
  - FAST: on tick, decrement rep_cnt. When it reaches 0, issue joy_step=dir and reload rep_fast.
  - SLOW/FAST: any change of dir (release, both pressed, reversal) goes to IDLE that cycle with no step. A held reversal is taken as a new press on the next cycle.
- Accumulator update, every cycle, in one registered assignment:
  - next = pending − emit + joy_step + (delta_valid && delta_ready ? sext(delta) : 0).
  - emit = ±1 when the stepper advanced this cycle, else 0.
  - The sum is computed at PEND_W+2 bits, then saturated to [−PMAX, +PMAX].
  - Simultaneous joystick, delta and emit contributions all apply in the same cycle.
- delta_ready = (|pending| <= PMAX−128) && !flush. This is combinational from registered pending, so an accepted delta can never saturate. Saturation is reachable only via the joystick.
- flush (highest priority below reset):
  - pending←0 and FSM←IDLE.
  - Any delta offered that cycle is not accepted (ready=0).
  - steer holds its current phase; the tick counter is unaffected.
- Latency:
  - A press at edge N gives pending=±1 after edge N+1.
  - steer changes on the first tick after that.
- Reset mid-operation: pending steps are discarded and steer returns to 00 asynchronously.

Decomposition:
- Package quad_pkg:
  - Phase encoding constants (PH0=00, PH1=10, PH2=11, PH3=01 for CW order).
  - Joystick FSM enum {IDLE, SLOW, FAST}.
  - Function sat_add(value, limit).
  - Function next_phase(phase, cw).
- Sub-module quad_phase_gen: tick counter plus phase stepper.
  - Inputs: step_div, pending sign/nonzero.
  - Outputs: steer, emit.
- The top level holds the joystick FSM, the delta handshake and the accumulator.

Test Plan:
- Reset, step_div=3, delta=+3 valid for 1 cycle → pending goes 3→0 over 3 ticks (every 4 clocks); steer goes 00→10→11→01; busy falls with the last edge.
- right held with rep_slow=2, rep_fast=1, ACCEL_AFTER=4, step_div=0 → steps issued at press, then every 2 ticks ×4, then every tick. Checked via the pending/edge count over 20 cycles.
- left and right pressed together, then right released → no step while both are held; a −1 step on release of right (becomes left-only press); CCW sequence 00→01.
- pending driven to PMAX−127 via deltas → delta_ready=0; after one emit drops it to PMAX−128, delta_ready=1; a delta=+127 is then accepted without exceeding PMAX.
- pending=+5 with flush asserted together with delta_valid (+10) → pending=0 next cycle, delta not accepted, steer unchanged, busy=0.
- Deassert reset_n mid-sequence (pending=+7, steer=11) → steer=00, pending=0 immediately, with no clock edge required.
